// File: rtl/register_packet_controller.sv
// register_packet_controller
//   Parses byte packets from a receive stream into register writes and reads.
//   A read is answered with a response packet on the transmit stream.
//   Packet in : SYNC, CMD (00 = write, 01 = read), ADDR, [DATA_LENGTH bytes MSB first]
//   Packet out: SYNC, ADDR, DATA_LENGTH bytes MSB first
//
// Ports
//   ipClk, ipReset          clock (rising edge), async active-high reset
//   ipRxData/ipRxValid      received byte and one-cycle strobe
//   opTxData/opTxValid      response byte, held until ipTxReady accepts it
//   ipTxReady               sink ready; a byte moves when valid and ready are both high
//   opAddress, opWrData     register address and write data
//   opWrEnable, opRdEnable  one-cycle register write / read strobes
//   ipRdData/ipRdValid      read data and its qualifier
//   opBusy                  high whenever the parser is not idle
//   opError                 one-cycle error pulse
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | hunting for SYNC, other bytes discarded silently
// GET_CMD   | waiting for command byte
// GET_ADDR  | waiting for address byte
// GET_DATA  | collecting write data bytes
// WRITE     | opWrEnable asserted for this single cycle
// READ_WAIT | waiting for ipRdValid or timeout
// SEND_SYNC | presenting SYNC on the transmit side
// SEND_ADDR | presenting the address
// SEND_DATA | presenting read data bytes, MSB first
module register_packet_controller #(
  parameter int unsigned DATA_LENGTH = 4,
  parameter logic [7:0]  SYNC        = 8'h55,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                       ipClk,
  input  logic                       ipReset,
  input  logic [7:0]                 ipRxData,
  input  logic                       ipRxValid,
  output logic [7:0]                 opTxData,
  output logic                       opTxValid,
  input  logic                       ipTxReady,
  output logic [7:0]                 opAddress,
  output logic [8*DATA_LENGTH-1:0]   opWrData,
  output logic                       opWrEnable,
  output logic                       opRdEnable,
  input  logic [8*DATA_LENGTH-1:0]   ipRdData,
  input  logic                       ipRdValid,
  output logic                       opBusy,
  output logic                       opError
);

  localparam int W   = 8 * DATA_LENGTH;
  localparam int BCW = $clog2(DATA_LENGTH) + 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_LENGTH - 1);
  localparam logic [TCW-1:0] LAST_WAIT = TCW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ_WAIT,
    SEND_SYNC,
    SEND_ADDR,
    SEND_DATA
  } state_t;

  state_t         state_q, state_d;
  logic           cmd_rd_q, cmd_rd_d;
  logic [7:0]     addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           rd_en_q, rd_en_d;
  logic           err_q, err_d;
  logic           rx_drop;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q  <= IDLE;
      cmd_rd_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      rd_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_rd_q <= cmd_rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      rd_en_q  <= rd_en_d;
      err_q    <= err_d;
    end
  end

  // Bytes arriving while the controller cannot parse them are lost and flagged.
  assign rx_drop = ipRxValid && (state_q == WRITE     || state_q == READ_WAIT ||
                                 state_q == SEND_SYNC || state_q == SEND_ADDR ||
                                 state_q == SEND_DATA);

  always_comb begin
    state_d  = state_q;
    cmd_rd_d = cmd_rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    rd_en_d  = 1'b0;
    err_d    = rx_drop;

    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        tcnt_d = '0;
        if (ipRxValid && ipRxData == SYNC) state_d = GET_CMD;
      end

      GET_CMD: begin
        if (ipRxValid) begin
          if (ipRxData == 8'h00) begin
            cmd_rd_d = 1'b0;
            state_d  = GET_ADDR;
          end else if (ipRxData == 8'h01) begin
            cmd_rd_d = 1'b1;
            state_d  = GET_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GET_ADDR: begin
        if (ipRxValid) begin
          addr_d = ipRxData;
          bcnt_d = '0;
          tcnt_d = '0;
          if (cmd_rd_q) begin
            rd_en_d = 1'b1;
            state_d = READ_WAIT;
          end else begin
            state_d = GET_DATA;
          end
        end
      end

      GET_DATA: begin
        if (ipRxValid) begin
          wdata_d = (wdata_q << 8) | W'(ipRxData);
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = WRITE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end

      WRITE: state_d = IDLE;

      READ_WAIT: begin
        tcnt_d = tcnt_q + TCW'(1);
        // Read data is ignored while the read strobe itself is high; when data
        // and timeout coincide the data is taken and no error is raised.
        if (ipRdValid && !rd_en_q) begin
          rdata_d = ipRdData;
          tcnt_d  = '0;
          state_d = SEND_SYNC;
        end else if (tcnt_q == LAST_WAIT) begin
          rdata_d = '1;
          err_d   = 1'b1;
          tcnt_d  = '0;
          state_d = SEND_SYNC;
        end
      end

      SEND_SYNC: if (ipTxReady) state_d = SEND_ADDR;

      SEND_ADDR: begin
        if (ipTxReady) begin
          bcnt_d  = '0;
          state_d = SEND_DATA;
        end
      end

      SEND_DATA: begin
        if (ipTxReady) begin
          rdata_d = rdata_q << 8;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opTxData = 8'h00;
    case (state_q)
      SEND_SYNC: opTxData = SYNC;
      SEND_ADDR: opTxData = addr_q;
      SEND_DATA: opTxData = rdata_q[W-1 -: 8];
      default:   opTxData = 8'h00;
    endcase
  end

  assign opTxValid  = (state_q == SEND_SYNC) || (state_q == SEND_ADDR) ||
                      (state_q == SEND_DATA);
  assign opAddress  = addr_q;
  assign opWrData   = wdata_q;
  assign opWrEnable = (state_q == WRITE);
  assign opRdEnable = rd_en_q;
  assign opBusy     = (state_q != IDLE);
  assign opError    = err_q;

endmodule

// File: doc/register_packet_controller.md
REGISTER_PACKET_CONTROLLER -- requirements
Module: register_packet_controller

Interface
REQ-001 Parameter DATA_LENGTH, default 4: bytes per register data word; data width W = 8*DATA_LENGTH.
REQ-002 Parameter SYNC, default 8'h55: packet start byte, both directions.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for read data.
REQ-004 ipClk  in  1  single clock; all logic on its rising edge.
REQ-005 ipReset  in  1  reset, asynchronous, active-high.
REQ-006 ipRxData  in  8  received byte; ipRxValid  in  1  byte strobe, one cycle per byte.
REQ-007 opTxData  out  8  response byte; opTxValid  out  1; ipTxReady  in  1  sink accepts.
REQ-008 opAddress  out  8  register address; opWrData  out  W  write data.
REQ-009 opWrEnable  out  1  one-cycle write strobe; opRdEnable  out  1  one-cycle read strobe.
REQ-010 ipRdData  in  W  read data; ipRdValid  in  1  read data qualifier.
REQ-011 opBusy  out  1  high in every state except IDLE; opError  out  1  one-cycle error pulse.

Function
REQ-012 Packets: SYNC, CMD, ADDR, then DATA_LENGTH bytes MSB first for CMD=8'h00 (write); no data bytes for CMD=8'h01 (read).
REQ-013 States: IDLE, GET_CMD, GET_ADDR, GET_DATA, WRITE, READ_WAIT, SEND_SYNC, SEND_ADDR, SEND_DATA.
REQ-014 IDLE: byte equal to SYNC -> GET_CMD; any other byte discarded, no error.
REQ-015 GET_CMD: 8'h00/8'h01 latched -> GET_ADDR; any other value -> opError pulse, IDLE.
REQ-016 GET_ADDR: byte latched to opAddress; write -> GET_DATA; read -> READ_WAIT with opRdEnable high for the following cycle.
REQ-017 GET_DATA: each byte shifted into opWrData from LSB end; after byte DATA_LENGTH -> WRITE.
REQ-018 WRITE: opWrEnable high exactly one cycle, opAddress/opWrData stable that cycle -> IDLE.
REQ-019 READ_WAIT: ipRdValid accepted from the cycle after opRdEnable; capture ipRdData -> SEND_SYNC.
REQ-020 READ_WAIT timeout: counter increments each cycle; on reaching TIMEOUT without ipRdValid, captured data = all ones, opError pulse, -> SEND_SYNC.
REQ-021 ipRdValid in the same cycle the counter reaches TIMEOUT: data wins, no error.
REQ-022 Response: SYNC, opAddress, then captured data MSB first; total 2+DATA_LENGTH bytes.
REQ-023 Tx handshake: byte transfers on a cycle with opTxValid and ipTxReady both high; opTxData stable while opTxValid high and ipTxReady low; next byte presented the cycle after transfer.
REQ-024 After last response byte transfers -> IDLE, opTxValid low that cycle.
REQ-025 Rx bytes arriving in WRITE, READ_WAIT or SEND_* are dropped, each with an opError pulse; no state change.
REQ-026 ipRxValid may be high on consecutive cycles; every byte in GET_* states is consumed without loss.
REQ-027 Only ipRxValid-qualified bytes advance the parser; gaps of any length between bytes are allowed.
REQ-028 At most one of opWrEnable, opRdEnable high in any cycle.

Reset
REQ-029 ipReset high: state IDLE, byte and timeout counters 0, all outputs 0, independent of ipClk.
REQ-030 Reset mid-packet or mid-response abandons it; no strobe and no further Tx byte after release.
REQ-031 First byte after reset release is parsed from IDLE.

Verification
REQ-032 Rx 55 00 10 12 34 56 78 -> one opWrEnable pulse, opAddress 8'h10, opWrData 32'h12345678; opBusy low after.
REQ-033 Rx 55 01 20, ipRdValid 2 cycles after opRdEnable with 32'hCAFEF00D, ipTxReady high -> Tx 55 20 CA FE F0 0D on 6 consecutive cycles.
REQ-034 Same read, ipTxReady toggling 1/0 -> identical byte sequence, each byte held while not ready.
REQ-035 Rx 55 01 30, no ipRdValid -> opError pulse after TIMEOUT cycles; Tx 55 30 FF FF FF FF.
REQ-036 Rx AA 55 07 -> AA ignored, opError pulse on 07, IDLE; following 55 00 ... write completes normally.
REQ-037 Reset asserted after third write-data byte -> no opWrEnable; subsequent full write packet executes correctly.
